// File: rtl/vga_frame_analyzer.sv
// VGA timing lock detector and per-frame lit-pixel statistics.
// Measures line/frame lengths, locks on stable timing, reports count and bbox.
module vga_frame_analyzer #(
  parameter int H_VIS_START = 285,
  parameter int H_VIS_END   = 1555,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [20:0] lit_count,
  output logic [10:0] bbox_xmin,
  output logic [10:0] bbox_xmax,
  output logic [9:0]  bbox_ymin,
  output logic [9:0]  bbox_ymax,
  output logic        frame_valid
);

  localparam logic [10:0] X_MAX = 11'h7FF;
  localparam logic [9:0]  Y_MAX = 10'h3FF;
  localparam logic [10:0] HV0 = 11'(H_VIS_START);
  localparam logic [10:0] HV1 = 11'(H_VIS_END);
  localparam logic [9:0]  VV0 = 10'(V_VIS_START);
  localparam logic [9:0]  VV1 = 10'(V_VIS_END);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_hs;
  logic        r_hs_d;
  logic        r_vs;
  logic        r_vs_fall;
  logic [11:0] r_rgb;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [10:0] r_ref_len;
  logic        r_first;
  logic        r_eq;
  logic [10:0] r_line_len;
  logic [9:0]  r_frame_lines;
  logic [20:0] r_cnt;
  logic [10:0] r_xmin;
  logic [10:0] r_xmax;
  logic [9:0]  r_ymin;
  logic [9:0]  r_ymax;
  logic [20:0] r_lit;
  logic [10:0] r_bx0;
  logic [10:0] r_bx1;
  logic [9:0]  r_by0;
  logic [9:0]  r_by1;
  logic        r_pend;
  logic        r_fv;

  logic        w_fall;
  logic        w_fs;
  logic [10:0] w_x;
  logic [9:0]  w_y;
  logic        w_sat;
  logic [10:0] w_len;
  logic [9:0]  w_flen;
  logic        w_loss;
  logic        w_copy;
  logic        w_lit;
  logic        w_cnt_en;
  logic [20:0] w_cnt_n;
  logic [10:0] w_xmin_n;
  logic [10:0] w_xmax_n;
  logic [9:0]  w_ymin_n;
  logic [9:0]  w_ymax_n;

  assign w_fall = r_hs_d & ~r_hs;
  assign w_fs   = w_fall & ~r_vs & r_vs_fall;
  assign w_len  = r_x + 11'd1;
  assign w_flen = r_y + 10'd1;

  // Coordinates of the sample currently held in the input registers
  always_comb begin
    w_x = (r_x == X_MAX) ? r_x : r_x + 11'd1;
    w_y = r_y;
    if (w_fall) begin
      w_x = '0;
      if (w_fs) w_y = '0;
      else if (r_y != Y_MAX) w_y = r_y + 10'd1;
    end
  end

  assign w_sat = (w_x == X_MAX) | (w_y == Y_MAX);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= SEARCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_loss = 1'b0;
    w_copy = 1'b0;
    unique case (r_state)
      SEARCH: if (w_fs) w_next = MEASURE;
      MEASURE: begin
        if (w_fs && r_eq && !r_first && (w_len == r_ref_len))
          w_next = LOCKED;
      end
      LOCKED: begin
        w_loss = w_sat
               | (w_fall & (w_len != r_line_len))
               | (w_fs & (w_flen != r_frame_lines));
        if (w_loss)    w_next = SEARCH;
        else if (w_fs) w_copy = 1'b1;
      end
      default: w_next = SEARCH;
    endcase
  end

  assign w_lit = (|r_rgb) && (w_x >= HV0) && (w_x < HV1)
              && (w_y >= VV0) && (w_y < VV1);
  assign w_cnt_en = (w_next != SEARCH);

  // Frame-start sample is merged into the freshly reloaded accumulators
  always_comb begin
    w_cnt_n  = w_fs ? '0    : r_cnt;
    w_xmin_n = w_fs ? X_MAX : r_xmin;
    w_xmax_n = w_fs ? '0    : r_xmax;
    w_ymin_n = w_fs ? Y_MAX : r_ymin;
    w_ymax_n = w_fs ? '0    : r_ymax;
    if (w_lit && w_cnt_en) begin
      w_cnt_n = w_cnt_n + 21'd1;
      if (w_x < w_xmin_n) w_xmin_n = w_x;
      if (w_x > w_xmax_n) w_xmax_n = w_x;
      if (w_y < w_ymin_n) w_ymin_n = w_y;
      if (w_y > w_ymax_n) w_ymax_n = w_y;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_hs          <= 1'b0;
      r_hs_d        <= 1'b0;
      r_vs          <= 1'b0;
      r_vs_fall     <= 1'b0;
      r_rgb         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_ref_len     <= '0;
      r_first       <= 1'b1;
      r_eq          <= 1'b0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_cnt         <= '0;
      r_xmin        <= X_MAX;
      r_xmax        <= '0;
      r_ymin        <= Y_MAX;
      r_ymax        <= '0;
      r_lit         <= '0;
      r_bx0         <= X_MAX;
      r_bx1         <= '0;
      r_by0         <= Y_MAX;
      r_by1         <= '0;
      r_pend        <= 1'b0;
      r_fv          <= 1'b0;
    end else begin
      r_hs   <= VGA_HS;
      r_hs_d <= r_hs;
      r_vs   <= VGA_VS;
      r_rgb  <= {VGA_R, VGA_G, VGA_B};
      r_x    <= w_x;
      r_y    <= w_y;
      if (w_fall) r_vs_fall <= r_vs;
      if (w_fs) begin
        r_first <= 1'b1;
        r_eq    <= 1'b1;
      end else if (r_state == MEASURE) begin
        if (w_fall) begin
          if (r_first) begin
            r_ref_len <= w_len;
            r_first   <= 1'b0;
          end else if (w_len != r_ref_len) begin
            r_eq <= 1'b0;
          end
        end
        if (w_sat) r_eq <= 1'b0;
      end
      if (r_state == MEASURE && w_next == LOCKED) begin
        r_line_len    <= r_ref_len;
        r_frame_lines <= w_flen;
      end
      r_cnt  <= w_cnt_n;
      r_xmin <= w_xmin_n;
      r_xmax <= w_xmax_n;
      r_ymin <= w_ymin_n;
      r_ymax <= w_ymax_n;
      if (w_copy) begin
        r_lit <= r_cnt;
        r_bx0 <= r_xmin;
        r_bx1 <= r_xmax;
        r_by0 <= r_ymin;
        r_by1 <= r_ymax;
      end
      r_pend <= w_copy;
      r_fv   <= r_pend;
    end
  end

  assign locked      = (r_state == LOCKED);
  assign line_len    = r_line_len;
  assign frame_lines = r_frame_lines;
  assign lit_count   = r_lit;
  assign bbox_xmin   = r_bx0;
  assign bbox_xmax   = r_bx1;
  assign bbox_ymin   = r_by0;
  assign bbox_ymax   = r_by1;
  assign frame_valid = r_fv;

endmodule

// File: tb/tb_vga_frame_analyzer.sv
// Directed bench for vga_frame_analyzer on a scaled-down 40x20 raster.
// Per-frame observations are logged, then compared against a vector table.
`timescale 1ns/1ps
module tb_vga_frame_analyzer;

  localparam int LW  = 40;
  localparam int FH  = 20;
  localparam int HSW = 6;
  localparam int VSW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs;
  logic        vs;
  logic [3:0]  vr;
  logic [3:0]  vg;
  logic [3:0]  vb;
  logic        locked;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [20:0] lit_count;
  logic [10:0] bbox_xmin;
  logic [10:0] bbox_xmax;
  logic [9:0]  bbox_ymin;
  logic [9:0]  bbox_ymax;
  logic        frame_valid;

  always #5 clk = ~clk;

  vga_frame_analyzer #(
    .H_VIS_START(8),
    .H_VIS_END(36),
    .V_VIS_START(3),
    .V_VIS_END(18)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .VGA_HS(hs),
    .VGA_VS(vs),
    .VGA_R(vr),
    .VGA_G(vg),
    .VGA_B(vb),
    .locked(locked),
    .line_len(line_len),
    .frame_lines(frame_lines),
    .lit_count(lit_count),
    .bbox_xmin(bbox_xmin),
    .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin),
    .bbox_ymax(bbox_ymax),
    .frame_valid(frame_valid)
  );

  typedef struct {
    int          pat;
    int          sy;
    logic        lk;
    int          nfv;
    logic [20:0] lit;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [9:0]  y0;
    logic [9:0]  y1;
  } vec_t;

  vec_t tv[11];

  int n_pass = 0;
  int n_tot  = 0;
  int fidx   = 0;

  logic        lock_start[32];
  logic        lock_mid[32];
  logic [20:0] lit_start[32];
  int          fv_cnt[32] = '{default: 0};
  logic [20:0] fv_lit[32];
  logic [41:0] fv_bb[32];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [11:0] pix(input int pat, input int x,
                                      input int y);
    case (pat)
      1: return 12'hFFF;
      2: return (x == 8 && y == 3) ? 12'h100 : 12'h000;
      3: return (x == 35 && y == 17) ? 12'h010 : 12'h000;
      4: return ((x == 7 && y == 3) || (x == 36 && y == 3) ||
                 (x == 8 && y == 2) || (x == 8 && y == 18))
                ? 12'hF0F : 12'h000;
      5: return (y == 10 && (x == 20 || x == 21)) ? 12'h001 : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic drive_lines(input int pat, input int ya, input int yb,
                             input int short_y);
    int len;
    for (int y = ya; y < yb; y++) begin
      len = (y == short_y) ? LW - 1 : LW;
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        hs = (x >= HSW);
        vs = (y >= VSW);
        {vr, vg, vb} = pix(pat, x, y);
        if (y == 0 && x == 4) begin
          lock_start[fidx] = locked;
          lit_start[fidx]  = lit_count;
        end
        if (y == 10 && x == 4) lock_mid[fidx] = locked;
      end
    end
  endtask

  task automatic run_frame(input int pat, input int short_y);
    drive_lines(pat, 0, FH, short_y);
    fidx++;
  endtask

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt[fidx]++;
      fv_lit[fidx] = lit_count;
      fv_bb[fidx]  = {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax};
    end
  end

  initial begin
    // Observations for row i appear at the start of frame i+1
    tv[0]  = '{0, -1, 1'b0, 0, 21'd0, 11'd2047, 11'd0, 10'd1023, 10'd0};
    tv[1]  = '{0, -1, 1'b1, 0, 21'd0, 11'd2047, 11'd0, 10'd1023, 10'd0};
    tv[2]  = '{0, -1, 1'b1, 1, 21'd0, 11'd2047, 11'd0, 10'd1023, 10'd0};
    tv[3]  = '{1, -1, 1'b1, 1, 21'd420, 11'd8, 11'd35, 10'd3, 10'd17};
    tv[4]  = '{2, -1, 1'b1, 1, 21'd1, 11'd8, 11'd8, 10'd3, 10'd3};
    tv[5]  = '{3, -1, 1'b1, 1, 21'd1, 11'd35, 11'd35, 10'd17, 10'd17};
    tv[6]  = '{4, -1, 1'b1, 1, 21'd0, 11'd2047, 11'd0, 10'd1023, 10'd0};
    tv[7]  = '{5, -1, 1'b1, 1, 21'd2, 11'd20, 11'd21, 10'd10, 10'd10};
    tv[8]  = '{0, 5, 1'b0, 0, 21'd0, 11'd2047, 11'd0, 10'd1023, 10'd0};
    tv[9]  = '{0, -1, 1'b1, 0, 21'd0, 11'd2047, 11'd0, 10'd1023, 10'd0};
    tv[10] = '{1, -1, 1'b1, 1, 21'd420, 11'd8, 11'd35, 10'd3, 10'd17};

    rst = 1'b1;
    hs  = 1'b0;
    vs  = 1'b0;
    {vr, vg, vb} = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 1'b0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_line_len", line_len, 0);
    chk("rst_frame_lines", frame_lines, 0);
    chk("rst_lit", lit_count, 0);
    chk("rst_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
        {11'd2047, 11'd0, 10'd1023, 10'd0});
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_frame(tv[i].pat, tv[i].sy);
    run_frame(1, -1);

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("row%0d_lock", i), lock_start[i+1], tv[i].lk);
      chk($sformatf("row%0d_fvcnt", i), fv_cnt[i+1], tv[i].nfv);
      if (tv[i].nfv > 0) begin
        chk($sformatf("row%0d_lit", i), fv_lit[i+1], tv[i].lit);
        chk($sformatf("row%0d_bbox", i), fv_bb[i+1],
            {tv[i].x0, tv[i].x1, tv[i].y0, tv[i].y1});
      end
    end
    chk("mid_lock_clean", lock_mid[7], 1'b1);
    chk("mid_lock_short", lock_mid[8], 1'b0);
    chk("hold_stats_after_loss", lit_start[9], 2);
    chk("line_len", line_len, LW);
    chk("frame_lines", frame_lines, FH);

    // Reset pulse in the middle of a locked frame
    drive_lines(0, 0, 8, -1);
    chk("pre_rst_lit", lit_start[12], 420);
    chk("pre_rst_locked", locked, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_locked", locked, 1'b0);
    chk("arst_lit", lit_count, 0);
    chk("arst_line_len", line_len, 0);
    chk("arst_frame_lines", frame_lines, 0);
    chk("arst_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
        {11'd2047, 11'd0, 10'd1023, 10'd0});
    drive_lines(0, 8, 9, -1);
    rst = 1'b0;
    drive_lines(0, 9, FH, -1);
    fidx++;
    run_frame(0, -1);
    run_frame(0, -1);
    run_frame(0, -1);
    drive_lines(0, 0, 3, -1);
    chk("rst_f1_lock", lock_start[13], 1'b0);
    chk("rst_f1_fv", fv_cnt[13], 0);
    chk("rst_f2_lock", lock_start[14], 1'b1);
    chk("rst_f2_fv", fv_cnt[14], 0);
    chk("rst_f3_fv", fv_cnt[15], 1);
    chk("rst_f4_lock", lock_start[16], 1'b1);

    // HS stuck high: x saturates about 2007 clocks in
    hs = 1'b1;
    vs = 1'b1;
    {vr, vg, vb} = 12'h000;
    repeat (1900) @(negedge clk);
    chk("sat_pre_lock", locked, 1'b1);
    repeat (1100) @(negedge clk);
    chk("sat_lock_lost", locked, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
